// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_ctrl
// Purpose  : Sequencer for an N x N output-stationary systolic array. On an
//            accepted start it captures A and B, clears the accumulators for
//            one cycle, then skews A rows into the left edge and B columns
//            into the top edge over 3N-2 cycles, and finally pulses done.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            start     - begin a multiply (honoured in IDLE only)
//            abort     - cancel while clearing/feeding, no done pulse
//            a_mat     - matrix A, row-major, element (i,j) at (i*N+j)*DW
//            b_mat     - matrix B, same layout
//            busy      - high whenever not IDLE
//            done      - one-cycle pulse, accumulators hold A x B
//            acc_rst   - accumulator clear for the array
//            acc_en    - accumulate enable for the array
//            shift_en  - operand shift enable for the array
//            in_left   - row feeds, element i at i*DW
//            in_top    - column feeds, element j at j*DW
// Revision : 1.0 - initial release
// ============================================================================
module systolic_ctrl #(
    parameter int MATRIX_SIZE = 3,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        abort,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] a_mat,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] b_mat,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        acc_rst,
    output logic                                        acc_en,
    output logic                                        shift_en,
    output logic [MATRIX_SIZE*DATA_WIDTH-1:0]           in_left,
    output logic [MATRIX_SIZE*DATA_WIDTH-1:0]           in_top
);

    localparam int c_N      = MATRIX_SIZE;
    localparam int c_DW     = DATA_WIDTH;
    localparam int c_T_LAST = 3 * c_N - 3;
    localparam int c_TW     = $clog2(3 * c_N - 1);
    localparam logic [c_TW-1:0] c_T_LAST_V = c_TW'(c_T_LAST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FEED  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [c_TW-1:0]               r_t;
    logic [c_N*c_N*c_DW-1:0]       r_a;
    logic [c_N*c_N*c_DW-1:0]       r_b;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Feed counter: only advances while remaining in FEED, so it stops at
    // the last feed step and is zero on entry from CLEAR.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t <= '0;
        end else if ((r_state == S_FEED) && (w_next == S_FEED)) begin
            r_t <= r_t + 1'b1;
        end else begin
            r_t <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Operand buffers: loaded only on the accepted start, frozen otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_a <= a_mat;
            r_b <= b_mat;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CLEAR;
            S_CLEAR: w_next = abort ? S_IDLE : S_FEED;
            S_FEED: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_t == c_T_LAST_V) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_DONE);
        acc_rst  = (r_state == S_CLEAR);
        acc_en   = (r_state == S_FEED);
        shift_en = (r_state == S_FEED);
    end

    // Skewed feeds: row i carries A[i][k] at step t = i + k, column j
    // carries B[k][j] at step t = k + j; all other slots are zero.
    always_comb begin
        in_left = '0;
        in_top  = '0;
        if (r_state == S_FEED) begin
            for (int i = 0; i < c_N; i++) begin
                for (int k = 0; k < c_N; k++) begin
                    if (int'(r_t) == i + k) begin
                        in_left[i*c_DW +: c_DW] = r_a[(i*c_N+k)*c_DW +: c_DW];
                        in_top[i*c_DW +: c_DW]  = r_b[(k*c_N+i)*c_DW +: c_DW];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_ctrl
// Purpose  : Self-checking bench for systolic_ctrl with a behavioural
//            output-stationary array attached; compares control timing,
//            skewed feeds and the resulting accumulators against A x B.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_ctrl;

    localparam int N      = 3;
    localparam int DW     = 8;
    localparam int T_LAST = 3 * N - 3;

    typedef logic [N*N*DW-1:0] mat_t;
    typedef logic [N*DW-1:0]   vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;
    mat_t a_mat;
    mat_t b_mat;
    logic busy, done, acc_rst, acc_en, shift_en;
    vec_t in_left, in_top;
    logic [4:0] ctl;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ctl = {busy, done, acc_rst, acc_en, shift_en};

    systolic_ctrl #(.MATRIX_SIZE(N), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .a_mat    (a_mat),
        .b_mat    (b_mat),
        .busy     (busy),
        .done     (done),
        .acc_rst  (acc_rst),
        .acc_en   (acc_en),
        .shift_en (shift_en),
        .in_left  (in_left),
        .in_top   (in_top)
    );

    // Behavioural array: each PE multiplies what arrives from its left and
    // top neighbours, accumulates, and passes the operands on.
    logic [DW-1:0] pe_a [N][N];
    logic [DW-1:0] pe_b [N][N];
    int            acc  [N][N];

    always @(posedge clk or posedge rst) begin
        logic [DW-1:0] ain, bin;
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pe_a[i][j] <= '0; pe_b[i][j] <= '0; acc[i][j] <= 0;
                end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    ain = (j == 0) ? in_left[i*DW +: DW] : pe_a[i][j-1];
                    bin = (i == 0) ? in_top[j*DW +: DW]  : pe_b[i-1][j];
                    if (acc_rst) begin
                        acc[i][j] <= 0; pe_a[i][j] <= '0; pe_b[i][j] <= '0;
                    end else if (shift_en) begin
                        pe_a[i][j] <= ain;
                        pe_b[i][j] <= bin;
                        if (acc_en) acc[i][j] <= acc[i][j] + int'(ain) * int'(bin);
                    end
                end
            end
        end
    end

    function automatic int el(input mat_t m, input int i, input int j);
        return int'(m[(i*N+j)*DW +: DW]);
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int k = 0; k < N*N; k++) m[k*DW +: DW] = DW'($urandom_range(0, 255));
        return m;
    endfunction

    function automatic mat_t mk_mat(input int v [N*N]);
        mat_t m;
        for (int k = 0; k < N*N; k++) m[k*DW +: DW] = DW'(v[k]);
        return m;
    endfunction

    function automatic vec_t exp_left(input mat_t a, input int t);
        vec_t v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i <= N - 1) v[i*DW +: DW] = DW'(el(a, i, t - i));
        return v;
    endfunction

    function automatic vec_t exp_top(input mat_t b, input int t);
        vec_t v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j <= N - 1) v[j*DW +: DW] = DW'(el(b, t - j, j));
        return v;
    endfunction

    function automatic int prod(input mat_t a, input mat_t b, input int i, input int j);
        int s = 0;
        for (int k = 0; k < N; k++) s += el(a, i, k) * el(b, k, j);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation from IDLE. Called at #1 after an edge with the DUT in
    // IDLE; returns at #1 after the edge that re-enters IDLE.
    task automatic do_op(input mat_t a, input mat_t b, input int abort_t, input int rst_t,
                         input bit hold, input bit scramble, input bit start_in_done,
                         input bit abort_in_idle);
        start = 1'b1; a_mat = a; b_mat = b;
        if (abort_in_idle) abort = 1'b1;
        chk("idle_before_start", ctl, 5'b00000);
        @(posedge clk); #1;
        abort = 1'b0;
        if (!hold) start = 1'b0;
        if (scramble) begin a_mat = rand_mat(); b_mat = rand_mat(); end
        chk("clear_ctl", ctl, 5'b10100);
        chk("clear_feeds", {in_left, in_top}, '0);
        for (int t = 0; t <= T_LAST; t++) begin
            @(posedge clk); #1;
            if (scramble) a_mat = rand_mat();
            chk("feed_ctl", ctl, 5'b10011);
            chk("feed_left", in_left, exp_left(a, t));
            chk("feed_top", in_top, exp_top(b, t));
            if (t == abort_t) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0; start = 1'b0;
                chk("abort_ctl", ctl, 5'b00000);
                chk("abort_feeds", {in_left, in_top}, '0);
                return;
            end
            if (t == rst_t) begin
                #3 rst = 1'b1;
                #1;
                chk("rst_async", {ctl, in_left, in_top}, '0);
                @(posedge clk); #1;
                chk("rst_held", {ctl, in_left, in_top}, '0);
                rst = 1'b0; start = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        chk("done_ctl", ctl, 5'b11000);
        chk("done_feeds", {in_left, in_top}, '0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("acc_%0d_%0d", i, j), acc[i][j], prod(a, b, i, j));
        if (start_in_done) start = 1'b1;
        @(posedge clk); #1;
        chk("after_done_idle", ctl, 5'b00000);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        mat_t ma, mi, m2;
        int va [N*N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int vi [N*N] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        int v2 [N*N] = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
        ma = mk_mat(va); mi = mk_mat(vi); m2 = mk_mat(v2);

        // Reset with activity on the inputs
        rst = 1'b1; start = 1'b1; abort = 1'b1; a_mat = rand_mat(); b_mat = rand_mat();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {ctl, in_left, in_top}, '0);
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", ctl, 5'b00000);

        // A x identity, then A x all-twos
        do_op(ma, mi, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(ma, m2, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort at t=3, then a clean operation
        do_op(rand_mat(), rand_mat(), 3, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_stays_idle", ctl, 5'b00000);
        end
        do_op(rand_mat(), rand_mat(), -1, -1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start held continuously with inputs changing mid-operation
        do_op(rand_mat(), rand_mat(), -1, -1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op(rand_mat(), rand_mat(), -1, -1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op(rand_mat(), rand_mat(), -1, -1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Start during DONE is ignored
        do_op(rand_mat(), rand_mat(), -1, -1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("done_start_ignored", ctl, 5'b00000);

        // Start and abort together in IDLE
        do_op(rand_mat(), rand_mat(), -1, -1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-FEED, then recovery
        do_op(rand_mat(), rand_mat(), -1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(rand_mat(), rand_mat(), -1, -1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random operations
        repeat (4) do_op(rand_mat(), rand_mat(), -1, -1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter MATRIX_SIZE, default 3: array dimension N.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: operand element width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request a new matrix multiply; sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  cancel the operation in progress; return to IDLE without done.
REQ-007 SHALL have port a_mat  input  [N][N] x DATA_WIDTH  matrix A, row-major, captured on the accepted start edge.
REQ-008 SHALL have port b_mat  input  [N][N] x DATA_WIDTH  matrix B, captured on the accepted start edge.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse: accumulators hold A x B.
REQ-011 SHALL have port acc_rst  output  1  clear for the array accumulators.
REQ-012 SHALL have port acc_en  output  1  accumulate enable for the array.
REQ-013 SHALL have port shift_en  output  1  operand shift enable for the array.
REQ-014 SHALL have port in_left  output  [N] x DATA_WIDTH  row feeds into the array's left edge.
REQ-015 SHALL have port in_top  output  [N] x DATA_WIDTH  column feeds into the array's top edge.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, CLEAR, FEED, DONE; all outputs SHALL be decoded from registered state, the counter t and the captured buffers.
REQ-017 In IDLE, start=1 SHALL capture a_mat/b_mat into internal buffers and move to CLEAR; start outside IDLE SHALL be ignored.
REQ-018 CLEAR SHALL last 1 cycle with acc_rst=1, acc_en=0, shift_en=0, and SHALL set t=0 on exit to FEED.
REQ-019 FEED SHALL last exactly 3N-2 cycles (t = 0 .. 3N-3) with acc_rst=0, acc_en=1, shift_en=1; t SHALL increment by 1 per cycle.
REQ-020 During FEED: in_left[i] SHALL be A[i][t-i] if 0 <= t-i <= N-1, else 0.
REQ-021 During FEED: in_top[j] SHALL be B[t-j][j] if 0 <= t-j <= N-1, else 0.
REQ-022 Outside FEED, in_left and in_top SHALL be all zero, and acc_en and shift_en SHALL be 0.
REQ-023 When t=3N-3, the FSM SHALL go to DONE on the next edge; DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-024 A start asserted during DONE SHALL be ignored; back-to-back operations therefore have at least one IDLE cycle between them.
REQ-025 The t counter SHALL be $clog2(3N-1) bits wide, SHALL never exceed 3N-3, and SHALL NOT wrap.
REQ-026 abort=1 in CLEAR or FEED SHALL force IDLE on the next edge with done=0; the accumulators are left as-is. abort in IDLE or DONE SHALL have no effect.
REQ-027 If start and abort are both high in IDLE, abort SHALL have no effect and start SHALL be accepted.
REQ-028 Captured buffers SHALL not change between the accepted start and the return to IDLE, regardless of a_mat/b_mat activity.
REQ-029 Latency SHALL be fixed: done is high in cycle 3N after the accepted start edge (CLEAR = cycle 1).

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, force state=IDLE and t=0.
REQ-031 While rst=1, outputs SHALL be: busy=0, done=0, acc_rst=0, acc_en=0, shift_en=0, in_left=0, in_top=0.
REQ-032 Captured buffers SHALL reset to 0.
REQ-033 Reset asserted mid-FEED SHALL abandon the operation with no done pulse; the first edge after deassertion SHALL behave as IDLE.

Verification
REQ-034 N=3, A=[[1,2,3],[4,5,6],[7,8,9]], B=identity, start pulse, with systolic_array attached -> acc_rst high in cycle 1, FEED in cycles 2-8, done in cycle 9, acc_out = A.
REQ-035 Same A, B = all 2 -> in_left[2] is 0,0,7,8,9,0,0 across FEED; acc_out row i = 2*rowsum(A[i]) in every column; busy high in cycles 1-9.
REQ-036 abort at FEED t=3 -> IDLE next cycle; done never pulses; busy low; a new start completes normally and gives correct results.
REQ-037 start held high continuously -> operations complete every 3N+1 = 10 cycles; each done pulse lasts 1 cycle; changing a_mat mid-operation does not affect that operation's results.
REQ-038 rst asserted asynchronously mid-FEED -> all outputs 0 before the next clk edge; after release, start yields correct results.
REQ-039 start and abort both high in IDLE -> operation accepted; CLEAR on the next cycle.
